// File: rtl/pn_code_rom.sv
// pn_code_rom: registered lookup of one 1024-chip period of the x^10+x^3+1 PN code,
// with DATA_WIDTH consecutive chips packed LSB-first into each word.
module pn_code_rom #(
   parameter int unsigned DATA_WIDTH = 1,
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ena,
   input  logic [ADDR_WIDTH-1:0] address_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out
);

   localparam int unsigned Depth    = 1 << ADDR_WIDTH;
   localparam int unsigned NumChips = 1024;

   // Ten seed ones, the m-sequence recurrence up to chip 1022, then a zero pad chip.
   // Evaluated in 32-chip blocks so each elaboration loop stays short.
   function automatic logic [NumChips-1:0] gen_chips();
      logic [NumChips-1:0] c;
      int                  k;
      c = '0;
      for (int blk = 0; blk < 32; blk++) begin
         for (int j = 0; j < 32; j++) begin
            k = blk * 32 + j;
            if (k < 10) begin
               c[10'(k)] = 1'b1;
            end else if (k < 1023) begin
               c[10'(k)] = c[10'(k - 7)] ^ c[10'(k - 10)];
            end else begin
               c[10'(k)] = 1'b0;
            end
         end
      end
      return c;
   endfunction

   localparam logic [NumChips-1:0] Chips = gen_chips();

   logic [DATA_WIDTH-1:0] rom [Depth];

   for (genvar n = 0; n < Depth; n++) begin : g_word
      for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
         localparam logic [9:0] Idx = 10'((n * DATA_WIDTH + i) % NumChips);
         assign rom[n][i] = Chips[Idx];
      end
   end

   logic [DATA_WIDTH-1:0] data_q;
   logic                  valid_q;

   // The address is only looked at when ena is high, so X on an idle bus is harmless.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= ena;
         if (ena) begin
            data_q <= rom[address_in];
         end
      end
   end

   assign data_out  = data_q;
   assign valid_out = valid_q;

endmodule

// File: tb/tb_pn_code_rom.sv
// tb_pn_code_rom: table vectors, full-period sweep and random reads of two ROM
// configurations against a chip-sequence model built from the recurrence.
module tb_pn_code_rom;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [9:0] address_in;
   logic       data_out;
   logic       valid_out;
   logic [3:0] data4;
   logic       valid4;

   int n_checks = 0;
   int n_fail   = 0;

   bit c_model [1024];
   bit got [1024];

   logic exp_v, exp_d, exp_v4;
   logic [3:0] exp_d4;

   typedef struct {
      logic       ena;
      logic [9:0] addr;
      logic       exp_valid;
      logic       exp_data;
   } vec_t;

   vec_t vecs [27];

   always #5 clk = ~clk;

   pn_code_rom #(.DATA_WIDTH(1), .ADDR_WIDTH(10)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .address_in (address_in),
      .data_out   (data_out),
      .valid_out  (valid_out)
   );

   pn_code_rom #(.DATA_WIDTH(4), .ADDR_WIDTH(8)) u_dut4 (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .address_in (address_in[7:0]),
      .data_out   (data4),
      .valid_out  (valid4)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] word4(input logic [7:0] n);
      logic [3:0] w;
      for (int i = 0; i < 4; i++) w[i] = c_model[(int'(n) * 4 + i) % 1024];
      return w;
   endfunction

   task automatic check_all(input string tag);
      check({tag, " valid"}, 32'(valid_out), 32'(exp_v));
      check({tag, " data"}, 32'(data_out), 32'(exp_d));
      check({tag, " valid4"}, 32'(valid4), 32'(exp_v4));
      check({tag, " data4"}, 32'(data4), 32'(exp_d4));
   endtask

   // Drive one cycle, advance the scoreboard, compare after the edge.
   task automatic drive_model(input logic e, input logic [9:0] a, input string tag);
      ena        = e;
      address_in = a;
      @(negedge clk);
      exp_v  = e;
      exp_v4 = e;
      if (e) begin
         exp_d  = c_model[a];
         exp_d4 = word4(a[7:0]);
      end
      check_all(tag);
   endtask

   initial begin
      logic [20:0] golden;
      int          ones;
      int          runs;
      bit          all_one;
      logic        e;

      for (int k = 0; k < 1024; k++) begin
         if (k < 10)        c_model[k] = 1'b1;
         else if (k < 1023) c_model[k] = c_model[k-7] ^ c_model[k-10];
         else               c_model[k] = 1'b0;
      end

      golden = 21'b0_111_0000000_1111111111;
      for (int k = 0; k < 21; k++) vecs[k] = '{1'b1, 10'(k), 1'b1, golden[k]};
      vecs[21] = '{1'b0, 10'bx, 1'b0, 1'b0};
      vecs[22] = '{1'b1, 10'd5, 1'b1, 1'b1};
      vecs[23] = '{1'b0, 10'bx, 1'b0, 1'b1};
      vecs[24] = '{1'b0, 10'bx, 1'b0, 1'b1};
      vecs[25] = '{1'b1, 10'd8, 1'b1, 1'b1};
      vecs[26] = '{1'b1, 10'd1023, 1'b1, 1'b0};

      // Reset held with ena high and an arbitrary address.
      rst_n      = 1'b0;
      ena        = 1'b1;
      address_in = 10'($urandom_range(0, 1023));
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("reset valid", 32'(valid_out), 32'd0);
         check("reset data", 32'(data_out), 32'd0);
         check("reset valid4", 32'(valid4), 32'd0);
         check("reset data4", 32'(data4), 32'd0);
         address_in = 10'($urandom_range(0, 1023));
      end
      rst_n = 1'b1;

      for (int j = 0; j < 27; j++) begin
         ena        = vecs[j].ena;
         address_in = vecs[j].addr;
         @(negedge clk);
         check("vec valid", 32'(valid_out), 32'(vecs[j].exp_valid));
         check("vec data", 32'(data_out), 32'(vecs[j].exp_data));
         check("vec valid4", 32'(valid4), 32'(vecs[j].exp_valid));
         if (vecs[j].ena && vecs[j].addr == 10'd0) check("w4 addr0", 32'(data4), 32'h0000000f);
         if (vecs[j].ena && vecs[j].addr == 10'd2) check("w4 addr2", 32'(data4), 32'h00000003);
      end
      exp_d  = 1'b0;
      exp_d4 = word4(8'hff);

      for (int a = 0; a < 1024; a++) begin
         drive_model(1'b1, 10'(a), "sweep");
         got[a] = data_out;
      end
      ones = 0;
      for (int a = 0; a < 1024; a++) ones += int'(got[a]);
      check("ones count", 32'(ones), 32'd512);
      runs = 0;
      for (int p = 0; p <= 1013; p++) begin
         all_one = 1'b1;
         for (int q = 0; q < 10; q++) all_one &= got[p+q];
         if (all_one) runs++;
      end
      check("ten-ones runs", 32'(runs), 32'd1);
      check("pad chip", 32'(got[1023]), 32'd0);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            drive_model(1'b1, 10'd1023, "wrap");
            drive_model(1'b1, 10'd0, "wrap");
         end else begin
            e = ($urandom_range(0, 3) != 0);
            drive_model(e, e ? 10'($urandom_range(0, 1023)) : 10'bx, "rand");
         end
      end

      // Asynchronous reset between edges while streaming.
      drive_model(1'b1, 10'd17, "pre-reset");
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      exp_v  = 1'b0;
      exp_v4 = 1'b0;
      exp_d  = 1'b0;
      exp_d4 = 4'd0;
      check_all("async reset");
      @(negedge clk);
      check_all("reset held");
      rst_n = 1'b1;
      #1;
      check_all("after release");
      drive_model(1'b1, 10'd17, "post-reset");
      drive_model(1'b0, 10'bx, "post-reset idle");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
